// File: rtl/vga_grid_pkg.sv
// Shared grid geometry, FSM state encoding and cell indexing for the VGA grid sampler.
package vga_grid_pkg;

  localparam int          CELL_W           = 160;
  localparam int          N_COLS           = 4;
  localparam int          N_ROWS           = 3;
  localparam int          N_CELLS          = N_COLS * N_ROWS;
  localparam logic [11:0] GRID_LINE_COLOUR = 12'hEEE;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    ACTIVE,
    DONE
  } grid_state_e;

  // Cells are numbered column-major: index = column * rows + row.
  function automatic int cell_idx(input int c, input int r);
    return c * N_ROWS + r;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Sync edge detection, pixel/line counters, active-window position and sticky timing-error flag.
module vga_sync_tracker #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int SYNC_POL = 0,
  parameter int PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        pix_en_i,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        tracking_i,
  output logic        hs_edge_o,
  output logic        vs_edge_o,
  output logic [10:0] vcnt_o,
  output logic [10:0] x_o,
  output logic [10:0] y_o,
  output logic        x_act_o,
  output logic        y_act_o,
  output logic        err_evt_o,
  output logic        hsat_o,
  output logic        sync_error_o
);

  localparam logic        POL     = 1'(SYNC_POL);
  localparam logic [10:0] CNT_MAX = '1;
  localparam int          H_OFF   = H_SYNC + H_BP + PIPE_DLY;
  localparam int          V_OFF   = V_SYNC + V_BP;

  logic               hs_q;
  logic               vs_q;
  logic [10:0]        hcnt_q;
  logic [10:0]        hcnt_d;
  logic [10:0]        vcnt_q;
  logic [10:0]        vcnt_d;
  logic [10:0]        vcnt_inc;
  logic               sync_error_q;
  logic signed [12:0] x_s;
  logic signed [12:0] y_s;

  assign hs_edge_o = pix_en_i && (hs_i == POL) && (hs_q != POL);
  assign vs_edge_o = pix_en_i && (vs_i == POL) && (vs_q != POL);
  assign hsat_o    = pix_en_i && !hs_edge_o && (hcnt_q == CNT_MAX - 11'd1);

  always_comb begin
    vcnt_inc = vcnt_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (hs_edge_o && (vcnt_q != CNT_MAX)) vcnt_inc = vcnt_q + 11'd1;
    if (pix_en_i) begin
      if (hs_edge_o)             hcnt_d = '0;
      else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 11'd1;
      // A coincident hs edge is counted first, then the vs edge restarts the frame.
      vcnt_d = vs_edge_o ? '0 : vcnt_inc;
    end
  end

  assign err_evt_o = hsat_o ||
                     (tracking_i && ((hs_edge_o && (hcnt_q + 11'd1 != 11'(H_TOTAL))) ||
                                     (vs_edge_o && (vcnt_inc != 11'(V_TOTAL)))));

  assign x_s     = $signed({2'b00, hcnt_q}) - $signed(13'(H_OFF));
  assign y_s     = $signed({2'b00, vcnt_q}) - $signed(13'(V_OFF));
  assign x_act_o = !x_s[12] && (x_s[11:0] < 12'(H_ACTIVE));
  assign y_act_o = !y_s[12] && (y_s[11:0] < 12'(V_ACTIVE));
  assign x_o     = x_s[10:0];
  assign y_o     = y_s[10:0];
  assign vcnt_o  = vcnt_q;
  assign sync_error_o = sync_error_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q         <= ~POL;
      vs_q         <= ~POL;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      sync_error_q <= 1'b0;
    end else begin
      if (pix_en_i) begin
        hs_q <= hs_i;
        vs_q <= vs_i;
      end
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (err_evt_o) sync_error_q <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_grid_sampler.sv
// Passive VGA bus monitor: samples the centre of each 4x3 grid cell and publishes once per clean frame.
// Optional build macro GRID_LINE_CHECK_EN adds the grid-line colour check driving line_error.
module vga_grid_sampler
  import vga_grid_pkg::*;
#(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int SYNC_POL = 0,
  parameter int PIPE_DLY = 1,
  parameter int CELL_PX  = CELL_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_en,
  input  logic                   hs,
  input  logic                   vs,
  input  logic [11:0]            colour_in,
  output logic [12*N_CELLS-1:0]  cell_colour,
  output logic                   frame_done,
  output logic                   sync_error,
  output logic                   line_error
);

  localparam int V_FIRST = V_SYNC + V_BP;
  localparam int V_LAST  = V_FIRST + V_ACTIVE - 1;

  grid_state_e state_q;
  grid_state_e state_d;
  logic        bad_q;
  logic        bad_d;
  logic        frame_done_q;
  logic        publish;
  logic        hs_edge;
  logic        vs_edge;
  logic [10:0] vcnt;
  logic [10:0] x;
  logic [10:0] y;
  logic        x_act;
  logic        y_act;
  logic        err_evt;
  logic        hsat;
  logic        in_window;

  vga_sync_tracker #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .SYNC_POL (SYNC_POL),
    .PIPE_DLY (PIPE_DLY)
  ) u_tracker (
    .clk          (clk),
    .rst_ni       (reset),
    .pix_en_i     (pix_en),
    .hs_i         (hs),
    .vs_i         (vs),
    .tracking_i   (state_q != HUNT),
    .hs_edge_o    (hs_edge),
    .vs_edge_o    (vs_edge),
    .vcnt_o       (vcnt),
    .x_o          (x),
    .y_o          (y),
    .x_act_o      (x_act),
    .y_act_o      (y_act),
    .err_evt_o    (err_evt),
    .hsat_o       (hsat),
    .sync_error_o (sync_error)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (vs_edge) state_d = SYNC;
      SYNC:    if (!vs_edge && pix_en && (vcnt == 11'(V_FIRST))) state_d = ACTIVE;
      ACTIVE: begin
        if (vs_edge)                                   state_d = SYNC;
        else if (hs_edge && (vcnt == 11'(V_LAST)))     state_d = DONE;
      end
      DONE:    state_d = SYNC;
      default: state_d = HUNT;
    endcase
    if (hsat) state_d = HUNT;

    // The frame opened straight out of HUNT has no verified length, so it is never published.
    bad_d = bad_q | err_evt;
    if (vs_edge) bad_d = (state_q == HUNT) | err_evt;
  end

  assign publish   = (state_q == DONE) && !bad_q && !err_evt;
  assign in_window = pix_en && (state_q == ACTIVE) && x_act && y_act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      bad_q        <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bad_q        <= bad_d;
      frame_done_q <= publish;
    end
  end

  assign frame_done = frame_done_q;

  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col
    for (genvar gj = 0; gj < N_ROWS; gj++) begin : g_row
      localparam int K = cell_idx(gi, gj);
      logic [11:0] shadow_q;
      logic [11:0] cell_q;
      logic        hit;

      assign hit = in_window && (x == 11'(CELL_PX / 2 + CELL_PX * gi)) &&
                   (y == 11'(CELL_PX / 2 + CELL_PX * gj));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_q <= '0;
          cell_q   <= '0;
        end else begin
          if (hit)     shadow_q <= colour_in;
          if (publish) cell_q   <= shadow_q;
        end
      end

      assign cell_colour[12*K +: 12] = cell_q;
    end
  end

`ifdef GRID_LINE_CHECK_EN
  logic [N_COLS-1:0] xsamp_hit;
  logic [N_COLS-2:0] xline_hit;
  logic [N_ROWS-1:0] ysamp_hit;
  logic [N_ROWS-2:0] yline_hit;
  logic              line_bad;
  logic              line_error_q;

  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_xchk
    assign xsamp_hit[gi] = (x == 11'(CELL_PX / 2 + CELL_PX * gi));
    if (gi < N_COLS - 1) begin : g_xline
      assign xline_hit[gi] = (x == 11'(CELL_PX * (gi + 1)));
    end
  end

  for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_ychk
    assign ysamp_hit[gi] = (y == 11'(CELL_PX / 2 + CELL_PX * gi));
    if (gi < N_ROWS - 1) begin : g_yline
      assign yline_hit[gi] = (y == 11'(CELL_PX * (gi + 1)));
    end
  end

  // Grid lines are probed where they cross the cell-centre rows and columns.
  assign line_bad = in_window &&
                    (((|xline_hit) && (|ysamp_hit)) || ((|yline_hit) && (|xsamp_hit))) &&
                    (colour_in != GRID_LINE_COLOUR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        line_error_q <= 1'b0;
    else if (line_bad) line_error_q <= 1'b1;
  end

  assign line_error = line_error_q;
`else
  assign line_error = 1'b0;
`endif

endmodule
